ps2_key_decoder: RTL and testbench

- Stateful successor to the combinational scan-code-to-ASCII translator.
- Consumes raw PS/2 set-2 scan bytes from the PS/2 receiver and parses E0/F0/E1 prefixes.
- Tracks modifier and Caps Lock state, translates each key event to the codebase key code, and buffers {release, ext, code} events in a show-ahead FIFO read by the CPU's keyboard port.

---
 rtl/ps2_kbd_pkg.sv | 62 ++++++
 rtl/ps2_key_xlat.sv | 89 ++++++++
 rtl/ps2_key_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared constants and types for the PS/2 keyboard decoder
package ps2_kbd_pkg;

    localparam logic [7:0] KC_UP   = 8'h04;
    localparam logic [7:0] KC_DN   = 8'h05;
    localparam logic [7:0] KC_LF   = 8'h06;
    localparam logic [7:0] KC_RT   = 8'h07;
    localparam logic [7:0] KC_BS   = 8'h08;
    localparam logic [7:0] KC_TAB  = 8'h09;
    localparam logic [7:0] KC_ENT  = 8'h0A;
    localparam logic [7:0] KC_HOME = 8'h0B;
    localparam logic [7:0] KC_END  = 8'h0C;
    localparam logic [7:0] KC_PGUP = 8'h0D;
    localparam logic [7:0] KC_PGDN = 8'h0E;
    localparam logic [7:0] KC_DEL  = 8'h0F;
    localparam logic [7:0] KC_F1   = 8'h10;
    localparam logic [7:0] KC_F2   = 8'h11;
    localparam logic [7:0] KC_F3   = 8'h12;
    localparam logic [7:0] KC_F4   = 8'h13;
    localparam logic [7:0] KC_F5   = 8'h14;
    localparam logic [7:0] KC_F6   = 8'h15;
    localparam logic [7:0] KC_F7   = 8'h16;
    localparam logic [7:0] KC_F8   = 8'h17;
    localparam logic [7:0] KC_F9   = 8'h18;
    localparam logic [7:0] KC_F10  = 8'h19;
    localparam logic [7:0] KC_F11  = 8'h1A;
    localparam logic [7:0] KC_ESC  = 8'h1B;
    localparam logic [7:0] KC_INS  = 8'h1C;
    localparam logic [7:0] KC_NUM  = 8'h1D;
    localparam logic [7:0] KC_F12  = 8'h1E;
    localparam logic [7:0] KC_SPC  = 8'h20;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Self-test, ack, resend and echo replies from the keyboard, never keys
    function automatic logic is_discard(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXTBRK,
        PS_PAUSE
    } ps_state_t;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } kbd_entry_t;

endpackage

// File: rtl/ps2_key_xlat.sv
// rtl/ps2_key_xlat.sv - scan byte plus modifier state to key code (US layout)
module ps2_key_xlat
    import ps2_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] scan,
    input  logic       shift,
    input  logic       caps,
    input  logic       ctrl,
    output logic [7:0] code
);

    function automatic logic [7:0] letter_of(input logic [7:0] s);
        case (s)
            8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
            8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
            8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
            8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
            8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
            8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
            8'h35: return 8'h79; 8'h1A: return 8'h7A;
            default: return 8'h00;
        endcase
    endfunction

    // Returns {shifted glyph, plain glyph}
    function automatic logic [15:0] glyph_of(input logic [7:0] s);
        case (s)
            8'h45: return 16'h2930; 8'h16: return 16'h2131; 8'h1E: return 16'h4032;
            8'h26: return 16'h2333; 8'h25: return 16'h2434; 8'h2E: return 16'h2535;
            8'h36: return 16'h5E36; 8'h3D: return 16'h2637; 8'h3E: return 16'h2A38;
            8'h46: return 16'h2839; 8'h0E: return 16'h7E60; 8'h4E: return 16'h5F2D;
            8'h55: return 16'h2B3D; 8'h54: return 16'h7B5B; 8'h5B: return 16'h7D5D;
            8'h5D: return 16'h7C5C; 8'h4C: return 16'h3A3B; 8'h52: return 16'h2227;
            8'h41: return 16'h3C2C; 8'h49: return 16'h3E2E; 8'h4A: return 16'h3F2F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] plain_special(input logic [7:0] s);
        case (s)
            8'h66: return KC_BS;  8'h0D: return KC_TAB; 8'h5A: return KC_ENT;
            8'h76: return KC_ESC; 8'h29: return KC_SPC; 8'h77: return KC_NUM;
            8'h05: return KC_F1;  8'h06: return KC_F2;  8'h04: return KC_F3;
            8'h0C: return KC_F4;  8'h03: return KC_F5;  8'h0B: return KC_F6;
            8'h83: return KC_F7;  8'h0A: return KC_F8;  8'h01: return KC_F9;
            8'h09: return KC_F10; 8'h78: return KC_F11; 8'h07: return KC_F12;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ext_special(input logic [7:0] s);
        case (s)
            8'h75: return KC_UP;   8'h72: return KC_DN;   8'h6B: return KC_LF;
            8'h74: return KC_RT;   8'h6C: return KC_HOME; 8'h69: return KC_END;
            8'h7D: return KC_PGUP; 8'h7A: return KC_PGDN; 8'h71: return KC_DEL;
            8'h70: return KC_INS;  8'h4A: return 8'h2F;   8'h5A: return KC_ENT;
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0]  letter;
    logic [15:0] glyph;
    logic [7:0]  pspec;
    logic [7:0]  xspec;

    assign letter = letter_of(scan);
    assign glyph  = glyph_of(scan);
    assign pspec  = plain_special(scan);
    assign xspec  = ext_special(scan);

    // Every mapped code is non-zero, so zero means "not in this table"
    always_comb begin
        code = scan;
        if (ext) begin
            if (xspec != 8'h00) code = xspec;
        end else if (letter != 8'h00) begin
            if (ctrl)
                code = (letter - 8'h20) & 8'h1F;
            else
                code = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else if (glyph != 16'h0000) begin
            code = shift ? glyph[15:8] : glyph[7:0];
        end else if (pspec != 8'h00) begin
            code = pspec;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 prefix parser, modifier tracker and key event FIFO
module ps2_key_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int REPORT_RELEASE = 1,
    parameter int TYPEMATIC      = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    input  logic                        rd,
    output logic                        out_empty,
    output logic [7:0]                  out_code,
    output logic                        out_release,
    output logic                        out_ext,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    input  logic                        clr_ovf,
    output logic [3:0]                  mods
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    ps_state_t  state, state_nx;
    logic [2:0] skip, skip_nx;
    logic       ev_fire, ev_rel_c, ev_ext_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= PS_IDLE;
            skip  <= 3'd0;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
        end
    end

    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        if (in_valid) begin
            case (state)
                PS_IDLE: begin
                    if (in_data == SC_E0)      state_nx = PS_EXT;
                    else if (in_data == SC_F0) state_nx = PS_BRK;
                    else if (in_data == SC_E1) begin
                        state_nx = PS_PAUSE;
                        skip_nx  = 3'd7;
                    end
                end
                PS_EXT: begin
                    if (in_data == SC_F0)      state_nx = PS_EXTBRK;
                    else if (in_data != SC_E0) state_nx = PS_IDLE;
                end
                PS_BRK, PS_EXTBRK: state_nx = PS_IDLE;
                PS_PAUSE: begin
                    skip_nx = skip - 3'd1;
                    if (skip <= 3'd1) state_nx = PS_IDLE;
                end
                default: state_nx = PS_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_fire  = 1'b0;
        ev_rel_c = 1'b0;
        ev_ext_c = 1'b0;
        if (in_valid) begin
            case (state)
                PS_IDLE: ev_fire = !(in_data inside {SC_E0, SC_F0, SC_E1}) && !is_discard(in_data);
                PS_EXT: begin
                    ev_fire  = (in_data != SC_F0) && (in_data != SC_E0);
                    ev_ext_c = 1'b1;
                end
                PS_BRK: begin
                    ev_fire  = 1'b1;
                    ev_rel_c = 1'b1;
                end
                PS_EXTBRK: begin
                    ev_fire  = 1'b1;
                    ev_rel_c = 1'b1;
                    ev_ext_c = 1'b1;
                end
                default: ev_fire = 1'b0;
            endcase
        end
    end

    // One-cycle event stage: state, mods and FIFO all move on the following edge
    logic       ev_valid, ev_rel, ev_ext;
    logic [7:0] ev_byte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ev_valid <= 1'b0;
            ev_rel   <= 1'b0;
            ev_ext   <= 1'b0;
            ev_byte  <= 8'h00;
        end else begin
            ev_valid <= ev_fire;
            ev_rel   <= ev_rel_c;
            ev_ext   <= ev_ext_c;
            ev_byte  <= in_data;
        end
    end

    logic       lsh, rsh, ctrl, alt, caps, caps_held;
    logic       last_valid;
    logic [8:0] last_key;
    logic       is_mod, same_key, drop_repeat, want_q;
    logic [7:0] xcode;

    assign is_mod      = ev_byte inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT, SC_CAPS};
    assign same_key    = last_valid && (last_key == {ev_ext, ev_byte});
    assign drop_repeat = (TYPEMATIC == 0) && same_key && !ev_rel;
    assign want_q      = ev_valid && !is_mod && (!ev_rel || (REPORT_RELEASE != 0)) && !drop_repeat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lsh        <= 1'b0;
            rsh        <= 1'b0;
            ctrl       <= 1'b0;
            alt        <= 1'b0;
            caps       <= 1'b0;
            caps_held  <= 1'b0;
            last_valid <= 1'b0;
            last_key   <= 9'd0;
        end else if (ev_valid) begin
            case (ev_byte)
                SC_LSHIFT: lsh  <= !ev_rel;
                SC_RSHIFT: rsh  <= !ev_rel;
                SC_CTRL:   ctrl <= !ev_rel;
                SC_ALT:    alt  <= !ev_rel;
                SC_CAPS: begin
                    if (ev_rel) begin
                        caps_held <= 1'b0;
                    end else if (!caps_held) begin
                        caps      <= !caps;
                        caps_held <= 1'b1;
                    end
                end
                default: begin
                    if (!ev_rel) begin
                        last_valid <= 1'b1;
                        last_key   <= {ev_ext, ev_byte};
                    end else if (same_key) begin
                        last_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    ps2_key_xlat u_xlat (
        .ext   (ev_ext),
        .scan  (ev_byte),
        .shift (lsh | rsh),
        .caps  (caps),
        .ctrl  (ctrl),
        .code  (xcode)
    );

    kbd_entry_t        mem [FIFO_DEPTH];
    kbd_entry_t        head;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push, pop;

    assign pop  = rd && (cnt != '0);
    assign push = want_q && ((cnt != CW'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{rel: ev_rel, ext: ev_ext, code: xcode};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (want_q && !push) overflow <= 1'b1;
            else if (clr_ovf)    overflow <= 1'b0;
        end
    end

    // Stale memory is masked so an empty FIFO always presents zeros
    assign head        = mem[rd_ptr];
    assign out_empty   = (cnt == '0);
    assign out_code    = out_empty ? 8'h00 : head.code;
    assign out_release = out_empty ? 1'b0 : head.rel;
    assign out_ext     = out_empty ? 1'b0 : head.ext;
    assign count       = cnt;
    assign mods        = {caps, alt, ctrl, lsh | rsh};

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       a_valid, a_rd, a_clr, b_valid, b_rd, b_clr;
    logic [7:0] a_data, b_data;
    logic       a_empty, a_rel, a_ext, a_ovf, b_empty, b_rel, b_ext, b_ovf;
    logic [7:0] a_code, b_code;
    logic [4:0] a_count;
    logic [2:0] b_count;
    logic [3:0] a_mods, b_mods;

    ps2_key_decoder dut_a (
        .clock(clock), .reset(reset), .in_valid(a_valid), .in_data(a_data), .rd(a_rd),
        .out_empty(a_empty), .out_code(a_code), .out_release(a_rel), .out_ext(a_ext),
        .count(a_count), .overflow(a_ovf), .clr_ovf(a_clr), .mods(a_mods)
    );

    ps2_key_decoder #(.FIFO_DEPTH(4), .REPORT_RELEASE(1), .TYPEMATIC(0)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_valid), .in_data(b_data), .rd(b_rd),
        .out_empty(b_empty), .out_code(b_code), .out_release(b_rel), .out_ext(b_ext),
        .count(b_count), .overflow(b_ovf), .clr_ovf(b_clr), .mods(b_mods)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Reference model for dut_a: flag-based prefix parsing and a queue of expected entries
    typedef struct {bit rel; bit ext; logic [7:0] code;} ent_t;
    ent_t mq[$];
    bit   m_ext, m_brk, lsh, rsh, ctl, alt, caps, held, m_ovf;
    int   m_skip;

    logic [7:0] lo_tab [256];
    logic [7:0] hi_tab [256];
    logic [7:0] nspec  [256];
    logic [7:0] xspec  [256];
    bit         is_let [256];

    logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] gly_sc [21] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                8'h41, 8'h49, 8'h4A};
    logic [7:0] plain_ch [21] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                                  8'h39, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27,
                                  8'h2C, 8'h2E, 8'h2F};
    logic [7:0] shift_ch [21] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A,
                                  8'h28, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22,
                                  8'h3C, 8'h3E, 8'h3F};
    logic [7:0] fk_sc  [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                                8'h09, 8'h78, 8'h07};
    logic [7:0] kpool  [21] = '{8'h1C, 8'h32, 8'h15, 8'h1A, 8'h45, 8'h16, 8'h4E, 8'h4A, 8'h5A,
                                8'h66, 8'h29, 8'h76, 8'h05, 8'h07, 8'h75, 8'h6B, 8'h12, 8'h59,
                                8'h14, 8'h11, 8'h58};
    logic [7:0] dpool  [6]  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    function automatic void init_tables();
        string letters = "abcdefghijklmnopqrstuvwxyz";
        for (int i = 0; i < 256; i++) begin
            lo_tab[i] = 8'h00; hi_tab[i] = 8'h00; nspec[i] = 8'h00; xspec[i] = 8'h00; is_let[i] = 0;
        end
        for (int i = 0; i < 26; i++) begin
            is_let[let_sc[i]] = 1;
            lo_tab[let_sc[i]] = letters[i];
            hi_tab[let_sc[i]] = letters[i] - 8'd32;
        end
        for (int i = 0; i < 21; i++) begin
            lo_tab[gly_sc[i]] = plain_ch[i];
            hi_tab[gly_sc[i]] = shift_ch[i];
        end
        for (int i = 0; i < 10; i++) nspec[fk_sc[i]] = 8'h10 + 8'(i);
        nspec[fk_sc[10]] = 8'h1A; nspec[fk_sc[11]] = 8'h1E;
        nspec[8'h66] = 8'h08; nspec[8'h0D] = 8'h09; nspec[8'h5A] = 8'h0A;
        nspec[8'h76] = 8'h1B; nspec[8'h29] = 8'h20; nspec[8'h77] = 8'h1D;
        xspec[8'h75] = 8'h04; xspec[8'h72] = 8'h05; xspec[8'h6B] = 8'h06; xspec[8'h74] = 8'h07;
        xspec[8'h6C] = 8'h0B; xspec[8'h69] = 8'h0C; xspec[8'h7D] = 8'h0D; xspec[8'h7A] = 8'h0E;
        xspec[8'h71] = 8'h0F; xspec[8'h70] = 8'h1C; xspec[8'h4A] = 8'h2F; xspec[8'h5A] = 8'h0A;
    endfunction

    function automatic logic [7:0] model_xlat(input bit ext, input logic [7:0] b);
        bit sh = lsh | rsh;
        if (ext) return (xspec[b] != 8'h00) ? xspec[b] : b;
        if (is_let[b]) begin
            if (ctl) return hi_tab[b] & 8'h1F;
            return (sh ^ caps) ? hi_tab[b] : lo_tab[b];
        end
        if (lo_tab[b] != 8'h00) return sh ? hi_tab[b] : lo_tab[b];
        if (nspec[b] != 8'h00) return nspec[b];
        return b;
    endfunction

    function automatic void model_event(input bit rel, input bit ext, input logic [7:0] b);
        ent_t e;
        if (b == 8'h12)      lsh = !rel;
        else if (b == 8'h59) rsh = !rel;
        else if (b == 8'h14) ctl = !rel;
        else if (b == 8'h11) alt = !rel;
        else if (b == 8'h58) begin
            if (rel) held = 0;
            else if (!held) begin caps = !caps; held = 1; end
        end else begin
            e.rel = rel; e.ext = ext; e.code = model_xlat(ext, b);
            if (mq.size() < 16) mq.push_back(e);
            else m_ovf = 1;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_skip > 0) begin m_skip--; return; end
        if (!m_brk) begin
            if (b == 8'hE0) begin m_ext = 1; return; end
            if (b == 8'hF0) begin m_brk = 1; return; end
            if (!m_ext && b == 8'hE1) begin m_skip = 7; return; end
            if (!m_ext && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) return;
        end
        model_event(m_brk, m_ext, b);
        m_brk = 0; m_ext = 0;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_skip = 0; m_ovf = 0;
        lsh = 0; rsh = 0; ctl = 0; alt = 0; caps = 0; held = 0;
    endfunction

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic settle();
        tick(); tick();
    endtask

    task automatic send_a(input logic [7:0] b);
        a_valid = 1'b1; a_data = b; tick(); a_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic send_b(input logic [7:0] b);
        b_valid = 1'b1; b_data = b; tick(); b_valid = 1'b0;
    endtask

    task automatic pop_a();
        a_rd = 1'b1; tick(); a_rd = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic pop_b();
        b_rd = 1'b1; tick(); b_rd = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        model_reset();
    endtask

    task automatic test_reset();
        tot_cnt++; if (a_empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", a_empty); else pass_cnt++;
        tot_cnt++; if (a_count !== 5'd0) $display("FAIL reset_count got %0d want 0", a_count); else pass_cnt++;
        tot_cnt++; if (a_ovf !== 1'b0) $display("FAIL reset_ovf got %0b want 0", a_ovf); else pass_cnt++;
        tot_cnt++; if (a_mods !== 4'h0) $display("FAIL reset_mods got %h want 0", a_mods); else pass_cnt++;
        tot_cnt++; if ({a_code, a_rel, a_ext} !== 10'd0) $display("FAIL reset_head got %h/%0b/%0b want 0", a_code, a_rel, a_ext); else pass_cnt++;
    endtask

    task automatic test_make_break();
        send_a(8'h1C);
        tot_cnt++; if (a_empty !== 1'b1) $display("FAIL latency_early got empty=%0b want 1", a_empty); else pass_cnt++;
        tick();
        tot_cnt++; if (a_empty !== 1'b0) $display("FAIL latency_n1 got empty=%0b want 0", a_empty); else pass_cnt++;
        send_a(8'hF0); send_a(8'h1C); settle();
        tot_cnt++; if (a_count !== 5'd2) $display("FAIL mb_count got %0d want 2", a_count); else pass_cnt++;
        tot_cnt++; if ({a_rel, a_ext, a_code} !== {1'b0, 1'b0, 8'h61}) $display("FAIL mb_make got %0b/%0b/%h want 0/0/61", a_rel, a_ext, a_code); else pass_cnt++;
        pop_a();
        tot_cnt++; if ({a_rel, a_ext, a_code} !== {1'b1, 1'b0, 8'h61}) $display("FAIL mb_break got %0b/%0b/%h want 1/0/61", a_rel, a_ext, a_code); else pass_cnt++;
        pop_a();
        tot_cnt++; if (a_empty !== 1'b1) $display("FAIL mb_drain got empty=%0b want 1", a_empty); else pass_cnt++;
    endtask

    task automatic test_shift();
        send_a(8'h12); settle();
        tot_cnt++; if (a_mods !== 4'b0001) $display("FAIL shift_on got %b want 0001", a_mods); else pass_cnt++;
        send_a(8'h1C); send_a(8'hF0); send_a(8'h12); settle();
        tot_cnt++; if (a_mods !== 4'b0000) $display("FAIL shift_off got %b want 0000", a_mods); else pass_cnt++;
        send_a(8'h1C); settle();
        tot_cnt++; if (a_count !== 5'd2) $display("FAIL shift_count got %0d want 2", a_count); else pass_cnt++;
        tot_cnt++; if (a_code !== 8'h41) $display("FAIL shift_upper got %h want 41", a_code); else pass_cnt++;
        pop_a();
        tot_cnt++; if (a_code !== 8'h61) $display("FAIL shift_lower got %h want 61", a_code); else pass_cnt++;
        pop_a();
    endtask

    task automatic test_caps();
        send_a(8'h58); send_a(8'h58); send_a(8'hF0); send_a(8'h58); settle();
        tot_cnt++; if (a_mods !== 4'b1000) $display("FAIL caps_once got %b want 1000", a_mods); else pass_cnt++;
        tot_cnt++; if (a_empty !== 1'b1) $display("FAIL caps_not_queued got empty=%0b want 1", a_empty); else pass_cnt++;
        send_a(8'h1C); settle();
        tot_cnt++; if (a_code !== 8'h41) $display("FAIL caps_upper got %h want 41", a_code); else pass_cnt++;
        pop_a();
        send_a(8'h12); send_a(8'h1C); send_a(8'hF0); send_a(8'h12); settle();
        tot_cnt++; if (a_code !== 8'h61) $display("FAIL caps_shift got %h want 61", a_code); else pass_cnt++;
        pop_a();
        send_a(8'h58); send_a(8'hF0); send_a(8'h58); settle();
        tot_cnt++; if (a_mods !== 4'b0000) $display("FAIL caps_off got %b want 0000", a_mods); else pass_cnt++;
    endtask

    task automatic test_ext_pause();
        send_a(8'hE0); send_a(8'h75); send_a(8'hE0); send_a(8'hF0); send_a(8'h75); settle();
        tot_cnt++; if ({a_rel, a_ext, a_code} !== {1'b0, 1'b1, 8'h04}) $display("FAIL ext_make got %0b/%0b/%h want 0/1/04", a_rel, a_ext, a_code); else pass_cnt++;
        pop_a();
        tot_cnt++; if ({a_rel, a_ext, a_code} !== {1'b1, 1'b1, 8'h04}) $display("FAIL ext_break got %0b/%0b/%h want 1/1/04", a_rel, a_ext, a_code); else pass_cnt++;
        pop_a();
        foreach (kpool[i]) if (i < 0) send_a(8'h00);
        send_a(8'hE1); send_a(8'h14); send_a(8'h77); send_a(8'hE1);
        send_a(8'hF0); send_a(8'h14); send_a(8'hF0); send_a(8'h77); send_a(8'h29); settle();
        tot_cnt++; if (a_count !== 5'd1) $display("FAIL pause_count got %0d want 1", a_count); else pass_cnt++;
        tot_cnt++; if ({a_rel, a_ext, a_code} !== {1'b0, 1'b0, 8'h20}) $display("FAIL pause_space got %0b/%0b/%h want 0/0/20", a_rel, a_ext, a_code); else pass_cnt++;
        pop_a();
    endtask

    task automatic test_ctrl_keys();
        send_a(8'h14); send_a(8'h1C); send_a(8'hF0); send_a(8'h14);
        send_a(8'hE0); send_a(8'h4A); send_a(8'hE0); send_a(8'h5A); settle();
        tot_cnt++; if (a_code !== 8'h01) $display("FAIL ctrl_a got %h want 01", a_code); else pass_cnt++;
        pop_a();
        tot_cnt++; if ({a_ext, a_code} !== {1'b1, 8'h2F}) $display("FAIL kp_slash got %0b/%h want 1/2F", a_ext, a_code); else pass_cnt++;
        pop_a();
        tot_cnt++; if ({a_ext, a_code} !== {1'b1, 8'h0A}) $display("FAIL kp_enter got %0b/%h want 1/0A", a_ext, a_code); else pass_cnt++;
        pop_a();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_codes [4] = '{8'h62, 8'h63, 8'h64, 8'h66};
        send_b(8'h1C); send_b(8'h32); send_b(8'h21); send_b(8'h23); send_b(8'h24); settle();
        tot_cnt++; if (b_count !== 3'd4) $display("FAIL ovf_count got %0d want 4", b_count); else pass_cnt++;
        tot_cnt++; if (b_ovf !== 1'b1) $display("FAIL ovf_set got %0b want 1", b_ovf); else pass_cnt++;
        // Pop lands on the same edge the pending make is pushed
        b_valid = 1'b1; b_data = 8'h2B; tick(); b_valid = 1'b0;
        b_rd = 1'b1; tick(); b_rd = 1'b0;
        tot_cnt++; if (b_count !== 3'd4) $display("FAIL ovf_pushpop got %0d want 4", b_count); else pass_cnt++;
        b_clr = 1'b1; tick(); b_clr = 1'b0;
        tot_cnt++; if (b_ovf !== 1'b0) $display("FAIL ovf_clear got %0b want 0", b_ovf); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tot_cnt++; if (b_code !== exp_codes[i]) $display("FAIL ovf_entry%0d got %h want %h", i, b_code, exp_codes[i]); else pass_cnt++;
            pop_b();
        end
        tot_cnt++; if (b_empty !== 1'b1) $display("FAIL ovf_drain got empty=%0b want 1", b_empty); else pass_cnt++;
    endtask

    task automatic test_typematic();
        send_b(8'h1C); send_b(8'h1C); send_b(8'h1C); send_b(8'hF0); send_b(8'h1C); send_b(8'h1C); settle();
        tot_cnt++; if (b_count !== 3'd3) $display("FAIL tm_count got %0d want 3", b_count); else pass_cnt++;
        tot_cnt++; if ({b_rel, b_code} !== {1'b0, 8'h61}) $display("FAIL tm_e0 got %0b/%h want 0/61", b_rel, b_code); else pass_cnt++;
        pop_b();
        tot_cnt++; if ({b_rel, b_code} !== {1'b1, 8'h61}) $display("FAIL tm_e1 got %0b/%h want 1/61", b_rel, b_code); else pass_cnt++;
        pop_b();
        tot_cnt++; if ({b_rel, b_code} !== {1'b0, 8'h61}) $display("FAIL tm_e2 got %0b/%h want 0/61", b_rel, b_code); else pass_cnt++;
        pop_b();
    endtask

    task automatic test_reset_mid();
        send_a(8'h12); send_a(8'h1C); send_a(8'hE0); send_a(8'hF0);
        send_b(8'h12); send_b(8'hE0); send_b(8'hF0); settle();
        pulse_reset();
        tot_cnt++; if ({a_empty, a_count, a_mods} !== {1'b1, 5'd0, 4'h0}) $display("FAIL rst_mid_a got %0b/%0d/%h want 1/0/0", a_empty, a_count, a_mods); else pass_cnt++;
        tot_cnt++; if (b_mods !== 4'h0) $display("FAIL rst_mid_bmods got %h want 0", b_mods); else pass_cnt++;
        send_a(8'h1C); send_b(8'h1C); settle();
        tot_cnt++; if ({a_rel, a_ext, a_code} !== {1'b0, 1'b0, 8'h61}) $display("FAIL rst_mid_aev got %0b/%0b/%h want 0/0/61", a_rel, a_ext, a_code); else pass_cnt++;
        tot_cnt++; if ({b_count, b_rel, b_ext, b_code} !== {3'd1, 1'b0, 1'b0, 8'h61}) $display("FAIL rst_mid_bev got %0d/%0b/%0b/%h want 1/0/0/61", b_count, b_rel, b_ext, b_code); else pass_cnt++;
        pop_a(); pop_b();
    endtask

    task automatic test_random();
        logic [7:0] k;
        for (int burst = 0; burst < 60; burst++) begin
            for (int n = 0; n < $urandom_range(1, 8); n++) begin
                case ($urandom_range(0, 9))
                    6: send_a(dpool[$urandom_range(0, 5)]);
                    7: begin
                        send_a(8'hE1); send_a(8'h14); send_a(8'h77); send_a(8'hE1);
                        send_a(8'hF0); send_a(8'h14); send_a(8'hF0); send_a(8'h77);
                    end
                    8: begin send_a(8'hE0); send_a(8'hE0); send_a(8'h75); end
                    9: send_a(8'($urandom_range(1, 8'hDF)));
                    default: begin
                        k = kpool[$urandom_range(0, 20)];
                        if ($urandom_range(0, 3) == 0) send_a(8'hE0);
                        if ($urandom_range(0, 2) == 0) send_a(8'hF0);
                        send_a(k);
                    end
                endcase
            end
            settle();
            tot_cnt++; if (a_count !== 5'(mq.size())) $display("FAIL rnd_count b%0d got %0d want %0d", burst, a_count, mq.size()); else pass_cnt++;
            tot_cnt++; if (a_mods !== {caps, alt, ctl, lsh | rsh}) $display("FAIL rnd_mods b%0d got %b want %b", burst, a_mods, {caps, alt, ctl, lsh | rsh}); else pass_cnt++;
            tot_cnt++; if (a_ovf !== m_ovf) $display("FAIL rnd_ovf b%0d got %0b want %0b", burst, a_ovf, m_ovf); else pass_cnt++;
            while (mq.size() > 0) begin
                tot_cnt++;
                if ({a_empty, a_rel, a_ext, a_code} !== {1'b0, mq[0].rel, mq[0].ext, mq[0].code})
                    $display("FAIL rnd_entry b%0d got e%0b r%0b x%0b %h want e0 r%0b x%0b %h",
                             burst, a_empty, a_rel, a_ext, a_code, mq[0].rel, mq[0].ext, mq[0].code);
                else pass_cnt++;
                pop_a();
            end
            tot_cnt++; if (a_empty !== 1'b1) $display("FAIL rnd_drain b%0d got empty=%0b want 1", burst, a_empty); else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_data = 8'h00;
        b_valid = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_data = 8'h00;
        init_tables();
        model_reset();
        tick(); tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_make_break();
        test_shift();
        test_caps();
        test_ext_pause();
        test_ctrl_keys();
        test_overflow();
        test_typematic();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
